// File: rtl/axil_demux_n.sv
// AXI4-Lite 1-to-N demultiplexer: base/mask decode, offset stripping, local DECERR for unmapped
// accesses. Define AXIL_DEMUX_N_TIMEOUT_EN to add a per-channel watchdog (SLVERR) with late-response drain.
module axil_demux_n #(
  parameter int unsigned N_PORTS        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [N_PORTS*ADDR_WIDTH-1:0] BASE_ADDR =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_PORTS*ADDR_WIDTH-1:0] ADDR_MASK = {4{32'hF000_0000}},
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [STRB_WIDTH-1:0]          s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [N_PORTS*ADDR_WIDTH-1:0]  m_awaddr,
  output logic [N_PORTS*3-1:0]           m_awprot,
  output logic [N_PORTS-1:0]             m_awvalid,
  input  logic [N_PORTS-1:0]             m_awready,
  output logic [N_PORTS*DATA_WIDTH-1:0]  m_wdata,
  output logic [N_PORTS*STRB_WIDTH-1:0]  m_wstrb,
  output logic [N_PORTS-1:0]             m_wvalid,
  input  logic [N_PORTS-1:0]             m_wready,
  input  logic [N_PORTS*2-1:0]           m_bresp,
  input  logic [N_PORTS-1:0]             m_bvalid,
  output logic [N_PORTS-1:0]             m_bready,
  output logic [N_PORTS*ADDR_WIDTH-1:0]  m_araddr,
  output logic [N_PORTS*3-1:0]           m_arprot,
  output logic [N_PORTS-1:0]             m_arvalid,
  input  logic [N_PORTS-1:0]             m_arready,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  m_rdata,
  input  logic [N_PORTS*2-1:0]           m_rresp,
  input  logic [N_PORTS-1:0]             m_rvalid,
  output logic [N_PORTS-1:0]             m_rready
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_DONE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_DONE} r_state_e;

  // Returns {hit, index}; scanning downward lets the lowest matching index win.
  function automatic logic [PW:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic          hit;
    logic [PW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = N_PORTS; i > 0; i--) begin
      if ((a & ADDR_MASK[(i-1)*ADDR_WIDTH +: ADDR_WIDTH]) == BASE_ADDR[(i-1)*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = PW'(i - 1);
      end
    end
    return {hit, idx};
  endfunction

  w_state_e                w_state_q, w_state_d;
  logic [PW-1:0]           w_port_q, w_port_d;
  logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
  logic [2:0]              w_prot_q, w_prot_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_d;
  logic                    aw_done_q, aw_done_d, wd_done_q, wd_done_d;
  logic [1:0]              bresp_q, bresp_d;

  r_state_e                r_state_q, r_state_d;
  logic [PW-1:0]           r_port_q, r_port_d;
  logic [ADDR_WIDTH-1:0]   r_addr_q, r_addr_d;
  logic [2:0]              r_prot_q, r_prot_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic [PW:0]             w_dec, r_dec;
  logic                    w_timeout, r_timeout;
  logic [N_PORTS-1:0]      w_drain, r_drain;

  assign w_dec = decode(s_awaddr);
  assign r_dec = decode(s_araddr);

  always_comb begin
    w_state_d = w_state_q;
    w_port_d  = w_port_q;
    w_addr_d  = w_addr_q;
    w_prot_d  = w_prot_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_done_d = aw_done_q;
    wd_done_d = wd_done_q;
    bresp_d   = bresp_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_awvalid && s_wvalid && !(w_dec[PW] && w_drain[w_dec[PW-1:0]])) begin
          s_awready = 1'b1;
          s_wready  = 1'b1;
          w_port_d  = w_dec[PW-1:0];
          w_addr_d  = s_awaddr & ~ADDR_MASK[w_dec[PW-1:0]*ADDR_WIDTH +: ADDR_WIDTH];
          w_prot_d  = s_awprot;
          w_data_d  = s_wdata;
          w_strb_d  = s_wstrb;
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          if (w_dec[PW]) begin
            w_state_d = W_FWD;
          end else begin
            bresp_d   = 2'b11;
            w_state_d = W_ERR;
          end
        end
      end
      W_FWD: begin
        aw_done_d = aw_done_q | m_awready[w_port_q];
        wd_done_d = wd_done_q | m_wready[w_port_q];
        if (aw_done_d && wd_done_d) begin
          w_state_d = W_RESP;
        end else if (w_timeout) begin
          bresp_d   = 2'b10;
          w_state_d = W_DONE;
        end
      end
      W_RESP: begin
        if (m_bvalid[w_port_q]) begin
          bresp_d   = m_bresp[w_port_q*2 +: 2];
          w_state_d = W_DONE;
        end else if (w_timeout) begin
          bresp_d   = 2'b10;
          w_state_d = W_DONE;
        end
      end
      W_ERR:   w_state_d = s_bready ? W_IDLE : W_DONE;
      W_DONE:  if (s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_port_d  = r_port_q;
    r_addr_d  = r_addr_q;
    r_prot_d  = r_prot_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    s_arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid && !(r_dec[PW] && r_drain[r_dec[PW-1:0]])) begin
          s_arready = 1'b1;
          r_port_d  = r_dec[PW-1:0];
          r_addr_d  = s_araddr & ~ADDR_MASK[r_dec[PW-1:0]*ADDR_WIDTH +: ADDR_WIDTH];
          r_prot_d  = s_arprot;
          if (r_dec[PW]) begin
            r_state_d = R_FWD;
          end else begin
            rdata_d   = '0;
            rresp_d   = 2'b11;
            r_state_d = R_DONE;
          end
        end
      end
      R_FWD: begin
        if (m_arready[r_port_q]) begin
          r_state_d = R_WAIT;
        end else if (r_timeout) begin
          rdata_d   = '0;
          rresp_d   = 2'b10;
          r_state_d = R_DONE;
        end
      end
      R_WAIT: begin
        if (m_rvalid[r_port_q]) begin
          rdata_d   = m_rdata[r_port_q*DATA_WIDTH +: DATA_WIDTH];
          rresp_d   = m_rresp[r_port_q*2 +: 2];
          r_state_d = R_DONE;
        end else if (r_timeout) begin
          rdata_d   = '0;
          rresp_d   = 2'b10;
          r_state_d = R_DONE;
        end
      end
      R_DONE:  if (s_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

`ifdef AXIL_DEMUX_N_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]      w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [N_PORTS-1:0] w_drain_q, w_drain_d, r_drain_q, r_drain_d;

  assign w_timeout = (w_state_q == W_FWD || w_state_q == W_RESP) && (w_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign r_timeout = (r_state_q == R_FWD || r_state_q == R_WAIT) && (r_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign w_drain   = w_drain_q;
  assign r_drain   = r_drain_q;

  // Drain is armed only once the request was fully issued; before that no response is owed.
  always_comb begin
    w_cnt_d   = (w_state_d != w_state_q || !(w_state_q == W_FWD || w_state_q == W_RESP)) ? '0 : w_cnt_q + 1'b1;
    r_cnt_d   = (r_state_d != r_state_q || !(r_state_q == R_FWD || r_state_q == R_WAIT)) ? '0 : r_cnt_q + 1'b1;
    w_drain_d = w_drain_q & ~m_bvalid;
    r_drain_d = r_drain_q & ~m_rvalid;
    if (w_timeout && w_state_q == W_RESP && !m_bvalid[w_port_q]) w_drain_d[w_port_q] = 1'b1;
    if (r_timeout && r_state_q == R_WAIT && !m_rvalid[r_port_q]) r_drain_d[r_port_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      w_drain_q <= '0;
      r_drain_q <= '0;
    end else begin
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      w_drain_q <= w_drain_d;
      r_drain_q <= r_drain_d;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign r_timeout = 1'b0;
  assign w_drain   = '0;
  assign r_drain   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_port_q  <= '0;
      w_addr_q  <= '0;
      w_prot_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      r_port_q  <= '0;
      r_addr_q  <= '0;
      r_prot_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_port_q  <= w_port_d;
      w_addr_q  <= w_addr_d;
      w_prot_q  <= w_prot_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_port_q  <= r_port_d;
      r_addr_q  <= r_addr_d;
      r_prot_q  <= r_prot_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_bvalid = (w_state_q == W_ERR) || (w_state_q == W_DONE);
  assign s_bresp  = bresp_q;
  assign s_rvalid = (r_state_q == R_DONE);
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

  always_comb begin
    m_awaddr  = '0;
    m_awprot  = '0;
    m_awvalid = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    m_araddr  = '0;
    m_arprot  = '0;
    m_arvalid = '0;
    m_rready  = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (w_state_q == W_FWD && w_port_q == PW'(i)) begin
        m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] = w_addr_q;
        m_awprot[i*3 +: 3]                   = w_prot_q;
        m_awvalid[i]                         = !aw_done_q;
        m_wdata[i*DATA_WIDTH +: DATA_WIDTH]  = w_data_q;
        m_wstrb[i*STRB_WIDTH +: STRB_WIDTH]  = w_strb_q;
        m_wvalid[i]                          = !wd_done_q;
      end
      if (r_state_q == R_FWD && r_port_q == PW'(i)) begin
        m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_addr_q;
        m_arprot[i*3 +: 3]                   = r_prot_q;
        m_arvalid[i]                         = 1'b1;
      end
      m_bready[i] = (w_state_q == W_RESP && w_port_q == PW'(i)) || w_drain[i];
      m_rready[i] = (r_state_q == R_WAIT && r_port_q == PW'(i)) || r_drain[i];
    end
  end

endmodule

// File: tb/tb_axil_demux_n.sv
// Directed self-checking bench for axil_demux_n (4 ports, default decode map).
module tb_axil_demux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [2:0]   s_awprot, s_arprot;
  logic [3:0]   s_wstrb;
  logic         s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic         s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]   s_bresp, s_rresp;
  logic [127:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [11:0]  m_awprot, m_arprot;
  logic [15:0]  m_wstrb;
  logic [3:0]   m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]   m_arvalid, m_arready, m_rvalid, m_rready;
  logic [7:0]   m_bresp, m_rresp;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  axil_demux_n #(.N_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    m_awready = 4'hF; m_wready = 4'hF; m_bvalid = '0; m_bresp = '0;
    m_arready = 4'hF; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
    tick(); tick();
    chk("rst_awready", s_awready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_m_valid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("rst_m_addr", m_awaddr | m_araddr | m_wdata, 0);
    rst = 1'b0;

    // Write 0x1000_0010 -> port 1, zero-wait slave
    tick();
    s_awaddr = 32'h1000_0010; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    #1;
    chk("wr1_accept", {s_awready, s_wready}, 2'b11);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("wr1_awvalid", m_awvalid, 4'b0010);
    chk("wr1_wvalid", m_wvalid, 4'b0010);
    chk("wr1_awaddr", m_awaddr, {32'h0, 32'h0, 32'h0000_0010, 32'h0});
    chk("wr1_wdata", m_wdata, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
    tick();
    chk("wr1_m_idle", m_awvalid | m_wvalid, 0);
    chk("wr1_bready", m_bready, 4'b0010);
    m_bvalid = 4'b0010; m_bresp = 8'b00_00_00_00;
    #1;
    chk("wr1_bvalid_early", s_bvalid, 0);
    tick();
    m_bvalid = '0;
    chk("wr1_bvalid_t3", s_bvalid, 1);
    chk("wr1_bresp", s_bresp, 2'b00);
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("wr1_done", s_bvalid, 0);

    // Read 0x2000_0004 -> port 2, 5 wait cycles
    s_araddr = 32'h2000_0004; s_arvalid = 1;
    #1;
    chk("rd2_accept", s_arready, 1);
    tick();
    s_arvalid = 0;
    chk("rd2_arvalid", m_arvalid, 4'b0100);
    chk("rd2_araddr", m_araddr, {32'h0, 32'h0000_0004, 64'h0});
    tick();
    chk("rd2_rready", m_rready, 4'b0100);
    chk("rd2_ar_off", m_arvalid, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("rd2_wait", s_rvalid, 0);
    end
    m_rvalid = 4'b0100; m_rresp = 8'b11_00_11_11;
    m_rdata = {32'hAAAA_AAAA, 32'h1234_5678, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
    tick();
    m_rvalid = '0;
    chk("rd2_rvalid", s_rvalid, 1);
    chk("rd2_rdata", s_rdata, 32'h1234_5678);
    chk("rd2_rresp", s_rresp, 2'b00);
    chk("rd2_others", {m_awvalid, m_wvalid, m_arvalid, m_bready}, 0);
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("rd2_done", s_rvalid, 0);

    // Unmapped read and write -> local DECERR at T+1
    s_araddr = 32'h5000_0000; s_arvalid = 1;
    s_awaddr = 32'h7000_0000; s_awvalid = 1; s_wvalid = 1;
    #1;
    chk("dec_accept", {s_arready, s_awready, s_wready}, 3'b111);
    tick();
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    chk("dec_rvalid", s_rvalid, 1);
    chk("dec_rresp", s_rresp, 2'b11);
    chk("dec_rdata", s_rdata, 0);
    chk("dec_bvalid", s_bvalid, 1);
    chk("dec_bresp", s_bresp, 2'b11);
    chk("dec_no_m", {m_arvalid, m_awvalid, m_wvalid}, 0);
    tick();
    chk("dec_b_held", {s_bvalid, s_bresp}, 3'b1_11);
    s_rready = 1; s_bready = 1;
    tick();
    s_rready = 0; s_bready = 0;
    chk("dec_done", {s_rvalid, s_bvalid}, 0);

    // Concurrent write to port 3 and read from port 0, responses stalled 3 cycles
    s_awaddr = 32'h3000_0100; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'h3; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 32'h0000_0008; s_arvalid = 1;
    #1;
    chk("cc_accept", {s_awready, s_arready}, 2'b11);
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("cc_valids", {m_awvalid, m_arvalid}, 8'b1000_0001);
    chk("cc_awaddr", m_awaddr, {32'h0000_0100, 96'h0});
    chk("cc_wstrb", m_wstrb, 16'h3000);
    chk("cc_araddr", m_araddr, {96'h0, 32'h0000_0008});
    tick();
    m_bvalid = 4'b1000; m_bresp = 8'b01_00_00_00;
    m_rvalid = 4'b0001; m_rresp = 8'b00_00_00_01;
    m_rdata = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hCAFE_F00D};
    tick();
    m_bvalid = '0; m_rvalid = '0; m_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk("cc_b_hold", {s_bvalid, s_bresp}, 3'b1_01);
      chk("cc_r_hold", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b01, 32'hCAFE_F00D});
    end
    s_bready = 1; s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
    chk("cc_done", {s_bvalid, s_rvalid}, 0);

    // Lone AW waits for W; then reset during W_RESP
    s_awaddr = 32'h0000_0020; s_awvalid = 1;
    #1;
    chk("lone_aw0", {s_awready, s_wready}, 0);
    tick();
    chk("lone_aw1", {s_awready, s_wready, m_awvalid}, 0);
    s_wdata = 32'h1111_2222; s_wstrb = 4'hF; s_wvalid = 1;
    #1;
    chk("lone_pair", {s_awready, s_wready}, 2'b11);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("rw_awvalid", m_awvalid, 4'b0001);
    tick();
    chk("rw_bready", m_bready, 4'b0001);
    rst = 1;
    tick();
    rst = 0;
    chk("rw_rst_ctl", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_bready, m_awvalid, m_wvalid}, 0);
    chk("rw_rst_data", m_awaddr | m_wdata, 0);
    chk("rw_rst_resp", {s_bresp, s_rresp, s_rdata}, 0);

    s_awaddr = 32'h2000_0040; s_wdata = 32'h0BAD_F00D; s_awvalid = 1; s_wvalid = 1;
    #1;
    chk("post_accept", {s_awready, s_wready}, 2'b11);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("post_awaddr", m_awaddr, {32'h0, 32'h0000_0040, 64'h0});
    tick();
    m_bvalid = 4'b0100; m_bresp = 8'b00_10_00_00;
    tick();
    m_bvalid = '0;
    chk("post_bresp", {s_bvalid, s_bresp}, 3'b1_10);
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("post_done", s_bvalid, 0);

`ifdef AXIL_DEMUX_N_TIMEOUT_EN
    // Hung port 1 read: SLVERR after 16 cycles in R_WAIT, late rvalid drained, next read succeeds
    s_araddr = 32'h1000_0000; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_wait", s_rvalid, 0);
      tick();
    end
    chk("to_resp", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b10, 32'h0});
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("to_drain_rdy", m_rready, 4'b0010);
    s_arvalid = 1;
    #1;
    chk("to_stall", s_arready, 0);
    m_rvalid = 4'b0010; m_rdata = {96'h0, 32'hDEAD_0000} << 32;
    tick();
    m_rvalid = '0;
    chk("to_drained", m_rready, 0);
    chk("to_no_resp", s_rvalid, 0);
    chk("to_accept", s_arready, 1);
    tick();
    s_arvalid = 0;
    tick();
    m_rvalid = 4'b0010; m_rresp = '0; m_rdata = {64'h0, 32'h7777_8888, 32'h0};
    tick();
    m_rvalid = '0;
    chk("to_next", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b00, 32'h7777_8888});
    s_rready = 1;
    tick();
    s_rready = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
